anton_neopixel_frame_sequencer: RTL

Sequences the neopixel stream datapath on the 6.4MHz domain. It issues the init handshake (initSlow/initSlowDone) and gates run. It counts completed frames using streamSyncOf and enforces a minimum frame period for a fixed refresh rate. It sits between the APB control registers and the stream logic, replacing direct software toggling of run/init.

---
 rtl/anton_neopixel_frame_sequencer_if.sv | 22 ++
 rtl/anton_neopixel_frame_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_frame_sequencer_if.sv
// Handshake between the frame sequencer and the neopixel stream logic:
// init request/acknowledge, run gate and the end-of-frame sync pulse.
interface anton_neopixel_frame_sequencer_if;
  logic initSlow;
  logic initSlowDone;
  logic run;
  logic streamSyncOf;

  modport master (
    output initSlow,
    output run,
    input  initSlowDone,
    input  streamSyncOf
  );

  modport slave (
    input  initSlow,
    input  run,
    output initSlowDone,
    output streamSyncOf
  );
endinterface

// File: rtl/anton_neopixel_frame_sequencer.sv
// Frame sequencer for the neopixel stream: init handshake, run gating, frame counting and
// minimum frame-period pacing. Define ANTON_NEOPIXEL_SEQ_WATCHDOG_EN to add the RUN watchdog.
module anton_neopixel_frame_sequencer #(
  parameter int PERIOD_BITS    = 16,
  parameter int COUNT_BITS     = 8,
  parameter int INIT_TIMEOUT   = 15
`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
  ,
  parameter int WATCHDOG_TICKS = 65535
`endif
) (
  input  logic                   clk6_4mhz,
  input  logic                   rstn,
  input  logic                   regStart,
  input  logic                   regStop,
  input  logic                   regLoop,
  input  logic [COUNT_BITS-1:0]  regFrameCount,
  input  logic [PERIOD_BITS-1:0] regFramePeriod,
  anton_neopixel_frame_sequencer_if.master strm,
  output logic                   busy,
  output logic                   frameDone,
  output logic [COUNT_BITS-1:0]  framesSent,
  output logic                   error
);

  localparam int TOUT_W = $clog2(INIT_TIMEOUT + 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(INIT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, INIT, RUN, GAP, STOPPING} state_t;

  state_t                 state_q, state_d;
  logic                   init_slow_q, init_slow_d;
  logic                   run_q, run_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [COUNT_BITS-1:0]  frames_sent_q, frames_sent_d;
  logic                   error_q, error_d;
  logic [PERIOD_BITS-1:0] timer_q, timer_d;
  logic [TOUT_W-1:0]      tout_q, tout_d;
  logic                   stop_q, stop_d;

`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WATCHDOG_TICKS + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WATCHDOG_TICKS - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  function automatic logic [PERIOD_BITS-1:0] sat_inc(input logic [PERIOD_BITS-1:0] v);
    return (&v) ? v : v + PERIOD_BITS'(1);
  endfunction

  // Compare against the timer value after this tick so start-to-start equals regFramePeriod.
  logic                  period_hit;
  logic [COUNT_BITS:0]   frame_target;
  logic                  last_frame;

  always_comb begin
    period_hit   = ({1'b0, timer_q} + (PERIOD_BITS+1)'(1)) >= {1'b0, regFramePeriod};
    frame_target = (regFrameCount == '0) ? (COUNT_BITS+1)'(1) : {1'b0, regFrameCount};
    last_frame   = ({1'b0, frames_sent_q} + (COUNT_BITS+1)'(1)) >= frame_target;
  end

  always_comb begin
    state_d       = state_q;
    init_slow_d   = init_slow_q;
    run_d         = run_q;
    frame_done_d  = 1'b0;
    frames_sent_d = frames_sent_q;
    error_d       = error_q;
    timer_d       = timer_q;
    tout_d        = tout_q;
    stop_d        = stop_q;
`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
    wdog_d        = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (regStart) begin
          state_d       = INIT;
          init_slow_d   = 1'b1;
          error_d       = 1'b0;
          frames_sent_d = '0;
          tout_d        = '0;
        end
      end
      INIT: begin
        if (regStop) begin
          state_d     = IDLE;
          init_slow_d = 1'b0;
        end else if (strm.initSlowDone) begin
          state_d     = RUN;
          init_slow_d = 1'b0;
          run_d       = 1'b1;
          timer_d     = '0;
`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
          wdog_d      = '0;
`endif
        end else if (tout_q == TOUT_LAST) begin
          state_d     = IDLE;
          init_slow_d = 1'b0;
          error_d     = 1'b1;
        end else begin
          tout_d = tout_q + TOUT_W'(1);
        end
      end
      RUN: begin
        timer_d = sat_inc(timer_q);
        if (regStop) stop_d = 1'b1;
        if (strm.streamSyncOf) begin
          frame_done_d  = 1'b1;
          frames_sent_d = frames_sent_q + COUNT_BITS'(1);
`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
          wdog_d        = '0;
`endif
          if (stop_q || regStop || (!regLoop && last_frame)) begin
            state_d = IDLE;
            run_d   = 1'b0;
            stop_d  = 1'b0;
          end else if (period_hit) begin
            timer_d = '0;
          end else begin
            state_d = GAP;
            run_d   = 1'b0;
          end
        end
`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          state_d = STOPPING;
          run_d   = 1'b0;
          error_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      GAP: begin
        timer_d = sat_inc(timer_q);
        if (regStop || stop_q) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else if (period_hit) begin
          state_d = RUN;
          run_d   = 1'b1;
          timer_d = '0;
`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end
      end
      STOPPING: begin
        state_d = IDLE;
        run_d   = 1'b0;
        stop_d  = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        run_d       = 1'b0;
        init_slow_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      init_slow_q   <= 1'b0;
      run_q         <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frames_sent_q <= '0;
      error_q       <= 1'b0;
      timer_q       <= '0;
      tout_q        <= '0;
      stop_q        <= 1'b0;
`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
      wdog_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      init_slow_q   <= init_slow_d;
      run_q         <= run_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frames_sent_q <= frames_sent_d;
      error_q       <= error_d;
      timer_q       <= timer_d;
      tout_q        <= tout_d;
      stop_q        <= stop_d;
`ifdef ANTON_NEOPIXEL_SEQ_WATCHDOG_EN
      wdog_q        <= wdog_d;
`endif
    end
  end

  assign strm.initSlow = init_slow_q;
  assign strm.run      = run_q;
  assign busy          = busy_q;
  assign frameDone     = frame_done_q;
  assign framesSent    = frames_sent_q;
  assign error         = error_q;

endmodule
